// File: rtl/if_prefetch_unit.sv
// Instruction-fetch front end: owns the fetch PC, reads instruction memory and buffers
// fetched words with their PC in a small FIFO for the decode stage.
module if_prefetch_unit #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  halt,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_addr,
  output logic [ADDR_WIDTH-1:0] im_addr,
  output logic                  im_rd,
  input  logic [DATA_WIDTH-1:0] im_r_data,
  output logic                  inst_valid,
  output logic [DATA_WIDTH-1:0] inst_data,
  output logic [ADDR_WIDTH-1:0] inst_pc,
  input  logic                  inst_ready,
  output logic                  busy
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] Full = CntW'(DEPTH);

  typedef enum logic [1:0] {StIdle, StRun, StHalted} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]       count_q, count_d;
  logic [DATA_WIDTH-1:0] data_q [DEPTH];
  logic [ADDR_WIDTH-1:0] pc_q [DEPTH];
  logic [DATA_WIDTH-1:0] last_data_q, last_data_d;
  logic [ADDR_WIDTH-1:0] last_pc_q, last_pc_d;

  logic run, pop, push, flush, redirect_take;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (halt) begin
          state_d = StHalted;
        end else if (start) begin
          state_d = StRun;
        end
      end
      StRun: begin
        if (halt) begin
          state_d = StHalted;
        end
      end
      StHalted: state_d = StHalted;
      default:  state_d = StIdle;
    endcase
  end

  // Output / control decode
  always_comb begin
    run           = (state_q == StRun);
    busy          = run;
    inst_valid    = (count_q != '0);
    pop           = inst_valid & inst_ready;
    im_rd         = run & ~halt & ~redirect_valid & ((count_q < Full) | pop);
    push          = im_rd;
    redirect_take = run & ~halt & redirect_valid;
    flush         = halt | redirect_take;
    im_addr       = fetch_pc_q;
    // Once drained, the head outputs keep showing the last word decode consumed
    inst_data     = inst_valid ? data_q[rd_ptr_q] : last_data_q;
    inst_pc       = inst_valid ? pc_q[rd_ptr_q] : last_pc_q;
  end

  // FIFO bookkeeping and fetch PC
  always_comb begin
    fetch_pc_d  = fetch_pc_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    last_data_d = last_data_q;
    last_pc_d   = last_pc_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      if (redirect_take) begin
        fetch_pc_d = redirect_addr;
      end
    end else begin
      if (push) begin
        wr_ptr_d   = wr_ptr_q + PtrW'(1);
        fetch_pc_d = fetch_pc_q + ADDR_WIDTH'(1);
      end
      if (pop) begin
        rd_ptr_d    = rd_ptr_q + PtrW'(1);
        last_data_d = data_q[rd_ptr_q];
        last_pc_d   = pc_q[rd_ptr_q];
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc_q  <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      last_data_q <= '0;
      last_pc_q   <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        data_q[i] <= '0;
        pc_q[i]   <= '0;
      end
    end else begin
      fetch_pc_q  <= fetch_pc_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      last_data_q <= last_data_d;
      last_pc_q   <= last_pc_d;
      if (push) begin
        data_q[wr_ptr_q] <= im_r_data;
        pc_q[wr_ptr_q]   <= fetch_pc_q;
      end
    end
  end

endmodule
